fetch_prefetch_buffer: RTL and testbench
========================================

# fetch_prefetch_buffer

Instruction prefetch buffer between the instruction memory port and the fetch→decode pipeline register. It owns the fetch PC, issues sequential word requests to a variable-latency in-order instruction memory, and queues returned instructions with their PC. It presents instructions to decode under a valid/ready stall handshake. On a taken branch or jump from execute it flushes and redirects, discarding responses still in flight.

## Interface
Parameters:
- DEPTH, 4: queue slots and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk_i  in  1  clock; one clock domain.
- reset_i  in  1  synchronous, active-high reset.
- redirect_i  in  1  branch/jump taken, driven from execute `pc_select`.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  32  word-aligned request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; in order, ≥1 cycle after grant.
- imem_rdata_i  in  32  instruction word.
- instr_valid_o  out  1  head instruction available.
- instr_o  out  32  head instruction.
- pc_o  out  32  PC of head instruction.
- pc_plus4_o  out  32  pc_o + 4, for the link/pc_src path.
- instr_ready_i  in  1  decode accepts; low = stall.

## Operation
- Slot queue of DEPTH entries: {pc, instr, filled}. Three pointers:
  - alloc_ptr: slot is allocated at grant, storing the PC.
  - fill_ptr: slot is filled at an accepted rvalid.
  - head_ptr: slot is popped on an output transfer.
- Counters, each $clog2(DEPTH)+1 bits:
  - count: allocated slots.
  - inflight: granted requests not yet returned, killed ones included.
  - kill: responses still to be discarded.
- Issue:
  - imem_req_o = ~reset_i & ~redirect_i & (count + kill < DEPTH).
  - imem_addr_o = fetch_pc.
  - On req & gnt: allocate a slot; fetch_pc += 4, wrapping modulo 2^32.
- While req & ~gnt, imem_addr_o holds stable. The only exception is redirect, which may withdraw an ungranted request, and imem must tolerate this.
- Response handling:
  - rvalid with kill > 0: drop the data; kill decrements.
  - rvalid with kill = 0: write the data into fill_ptr, set filled, advance fill_ptr.
  - Every rvalid decrements inflight.
- Output:
  - instr_valid_o = head.filled & ~redirect_i.
  - Transfer = instr_valid_o & instr_ready_i; it frees the head slot.
- Redirect cycle:
  - All slots are cleared and count becomes 0.
  - Next fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - Next kill = inflight − rvalid_i; next inflight is the same value.
  - Any rvalid arriving this cycle is discarded.
  - No transfer occurs, even if instr_ready_i is high.
- Reset:
  - fetch_pc = RESET_PC; all counters and pointers are 0; filled bits are cleared.
  - Outputs read imem_req_o = 0 and instr_valid_o = 0.
  - instr_o, pc_o and pc_plus4_o are don't-care while instr_valid_o = 0.
- Reset mid-operation: outstanding responses that arrive after reset are not tracked, so the imem must be reset together with this block.

## Timing
- Best-case latency: grant in cycle N and rvalid in N+1 give instr_valid_o in N+2, because the slot write is registered.
- With a 1-cycle memory and instr_ready_i held high, throughput is one instruction per cycle.
- Redirect in cycle R:
  - First request for redirect_pc is in R+1.
  - First redirected instruction is visible no earlier than R+3.
- Boundary cases:
  - Full (count + kill = DEPTH): imem_req_o is low until a pop or a killed return frees capacity.
  - Empty: instr_valid_o stays low; a response is not bypassed to the output.
  - Simultaneous grant, fill and pop: all three are legal in one cycle; count changes by +1 −1 = 0.
  - Pointer wrap: pointers wrap modulo DEPTH.
  - Decode stall: instr_valid_o, instr_o and pc_o hold stable while instr_ready_i is low.

## Structure
- Shared package/header `fetch_pkg`: XLEN = 32, the RESET_PC default and the instruction-alignment constant. The same header is used by the fetch and decode stages.
- Sub-module `fetch_slot_queue` holds the slot storage and the alloc/fill/head pointers with their filled bits. The top level holds fetch_pc, the counters, the issue logic and the redirect logic.

## Test plan
- Reset, then a 1-cycle imem with gnt always high:
  - Instructions appear at 0x0, 0x4, 0x8, … one per cycle.
  - First instr_valid_o is 2 cycles after the first grant.
- Hold instr_ready_i low for 10 cycles:
  - Exactly 4 grants occur, then imem_req_o drops.
  - pc_o stays at 0x0 throughout.
  - On release, pops resume in order.
- Memory latency of 3 cycles with redirect_pc_i = 0x100 asserted while 3 requests are in flight:
  - The 3 stale responses are dropped.
  - The next visible pc_o is 0x100.
- Redirect in the same cycle as rvalid and instr_ready_i:
  - No transfer occurs.
  - kill = inflight − 1.
  - After flush, 0x200 is the first PC issued.
- Hold gnt low for 5 cycles: imem_addr_o is stable at the pending PC for all 5 cycles.
- Redirect to 0x1003: the request address is 0x1000.
- Assert reset_i mid-stream: in the following cycle imem_req_o = 0 and instr_valid_o = 0, and the next request is to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode constants and PC helpers
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  // Instructions are word aligned; low address bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// rtl/fetch_slot_queue.sv - slot storage with alloc/fill/head pointers
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output logic            head_filled_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]    head_ptr_q, head_ptr_d;

  // Pointer advance; DEPTH is a power of two so wrap is free.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q + PW'(alloc_i);
    fill_ptr_d  = fill_ptr_q + PW'(fill_i);
    head_ptr_d  = head_ptr_q + PW'(pop_i);
    if (flush_i) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
    end
  end

  // Pointer and filled-bit registers, cleared by reset and by a flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      if (flush_i) begin
        filled_q <= '0;
      end else begin
        // The fill slot is never the filled head slot, so these cannot collide.
        if (fill_i) filled_q[fill_ptr_q] <= 1'b1;
        if (pop_i)  filled_q[head_ptr_q] <= 1'b0;
      end
    end
  end

  // Payload storage; contents are only meaningful behind a filled bit.
  always_ff @(posedge clk_i) begin
    if (alloc_i) pc_q[alloc_ptr_q]   <= alloc_pc_i;
    if (fill_i)  instr_q[fill_ptr_q] <= fill_data_i;
  end

  assign head_filled_o = filled_q[head_ptr_q];
  assign head_pc_o     = pc_q[head_ptr_q];
  assign head_instr_o  = instr_q[head_ptr_q];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - instruction prefetch buffer with flush/redirect
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAPACITY = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW:0]     occupancy;
  logic            grant, fill, drop, pop, head_filled;
  logic [XLEN-1:0] head_pc;

  // Killed responses still hold capacity: they will arrive and must be absorbed.
  assign occupancy  = {1'b0, count_q} + {1'b0, kill_q};
  assign imem_req_o = ~reset_i & ~redirect_i & (occupancy < CAPACITY);
  assign imem_addr_o = fetch_pc_q;
  assign grant = imem_req_o & imem_gnt_i;
  assign drop  = imem_rvalid_i & (kill_q != '0);
  assign fill  = imem_rvalid_i & (kill_q == '0) & ~redirect_i;

  assign instr_valid_o = head_filled & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign pc_o          = head_pc;
  assign pc_plus4_o    = head_pc + INSTR_BYTES;

  fetch_slot_queue #(.DEPTH(DEPTH)) u_slots (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (redirect_i),
    .alloc_i      (grant),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rdata_i),
    .pop_i        (pop),
    .head_filled_o(head_filled),
    .head_pc_o    (head_pc),
    .head_instr_o (instr_o)
  );

  // Next fetch PC and bookkeeping counters; a redirect turns every in-flight request into a kill.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
      count_d    = '0;
      inflight_d = inflight_q - CW'(imem_rvalid_i);
      kill_d     = inflight_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + INSTR_BYTES;
      count_d    = count_q + CW'(grant) - CW'(pop);
      inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);
      if (drop) kill_d = kill_q - CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - randomized self-checking bench for fetch_prefetch_buffer
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_i, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .instr_ready_i(instr_ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          killed;
  } resp_t;

  // Memory: outstanding responses in order. Buffer: PCs of live returned words.
  resp_t       memq[$];
  logic [31:0] bufq[$];
  logic [31:0] exp_pc;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  bit          rst_now, redir_now, prev_rst;
  logic [31:0] redir_pc_now;
  int          gnt_pct, ready_pct, lat_min, lat_max;

  bit          o_req, o_gnt, o_valid, o_xfer, o_rv;
  logic [31:0] o_addr, o_pc;
  int          o_cyc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic cycle();
    bit    rv, g, rdy, exp_req, exp_valid;
    int    occ;
    resp_t r;
    @(negedge clk);
    rv  = !rst_now && memq.size() > 0 && memq[0].due <= cyc;
    g   = $urandom_range(99) < gnt_pct;
    rdy = $urandom_range(99) < ready_pct;
    reset_i       = rst_now;
    redirect_i    = redir_now;
    redirect_pc_i = redir_pc_now;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? memword(memq[0].addr) : 32'h0;
    instr_ready_i = rdy;
    #1;
    occ       = bufq.size() + memq.size();
    exp_req   = !rst_now && !redir_now && occ < DEPTH;
    exp_valid = !rst_now && !redir_now && bufq.size() > 0;
    n_cmp++;
    if (imem_req_o !== exp_req) begin
      n_fail++;
      $display("FAIL req: got %b want %b (cycle %0d)", imem_req_o, exp_req, cyc);
    end
    if (!rst_now) begin
      if (exp_req) begin
        n_cmp++;
        if (imem_addr_o !== exp_pc) begin
          n_fail++;
          $display("FAIL addr: got %h want %h (cycle %0d)", imem_addr_o, exp_pc, cyc);
        end
      end
      n_cmp++;
      if (instr_valid_o !== exp_valid) begin
        n_fail++;
        $display("FAIL valid: got %b want %b (cycle %0d)", instr_valid_o, exp_valid, cyc);
      end
      if (exp_valid && instr_valid_o === 1'b1) begin
        n_cmp++;
        if (pc_o !== bufq[0] || instr_o !== memword(bufq[0]) || pc_plus4_o !== bufq[0] + 32'd4) begin
          n_fail++;
          $display("FAIL head: got pc %h instr %h pc4 %h want pc %h instr %h pc4 %h (cycle %0d)",
                   pc_o, instr_o, pc_plus4_o, bufq[0], memword(bufq[0]), bufq[0] + 32'd4, cyc);
        end
      end
    end else if (prev_rst) begin
      n_cmp++;
      if (instr_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid: got %b want 0 (cycle %0d)", instr_valid_o, cyc);
      end
    end
    o_req = imem_req_o; o_gnt = g; o_addr = imem_addr_o; o_valid = instr_valid_o;
    o_pc = pc_o; o_xfer = instr_valid_o & rdy; o_rv = rv; o_cyc = cyc;
    @(posedge clk);
    if (rst_now) begin
      memq.delete();
      bufq.delete();
      exp_pc = RESET_PC;
    end else begin
      if (exp_valid && rdy) void'(bufq.pop_front());
      if (rv) begin
        r = memq.pop_front();
        if (!r.killed && !redir_now) bufq.push_back(r.addr);
      end
      if (redir_now) begin
        bufq.delete();
        foreach (memq[i]) memq[i].killed = 1'b1;
        exp_pc = {redir_pc_now[31:2], 2'b00};
      end else if (o_req && g) begin
        r.addr   = o_addr;
        r.due    = cyc + int'($urandom_range(lat_max, lat_min));
        r.killed = 1'b0;
        memq.push_back(r);
        exp_pc = exp_pc + 32'd4;
      end
    end
    prev_rst = rst_now;
    cyc++;
  endtask

  task automatic knobs(input int gp, input int rp, input int lmin, input int lmax);
    gnt_pct = gp; ready_pct = rp; lat_min = lmin; lat_max = lmax;
    redir_now = 1'b0; rst_now = 1'b0;
  endtask

  task automatic do_reset();
    rst_now = 1'b1;
    repeat (2) cycle();
    rst_now = 1'b0;
  endtask

  task automatic test_reset();
    knobs(100, 100, 1, 1);
    do_reset();
    cycle();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req %b addr %h want 1 %h", o_req, o_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int fg, fv, xf;
    knobs(100, 100, 1, 1);
    do_reset();
    fg = -1; fv = -1; xf = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (o_req && o_gnt && fg < 0) fg = o_cyc;
      if (o_valid && fv < 0) fv = o_cyc;
      if (i >= 10 && o_xfer) xf++;
    end
    n_cmp++;
    if (fv - fg != 2) begin
      n_fail++;
      $display("FAIL first_latency: got %0d want 2", fv - fg);
    end
    n_cmp++;
    if (xf != 10) begin
      n_fail++;
      $display("FAIL throughput: got %0d want 10", xf);
    end
  endtask

  task automatic test_stall();
    int grants;
    logic [31:0] first_pc;
    bit seen;
    knobs(100, 0, 1, 1);
    do_reset();
    grants = 0;
    repeat (10) begin
      cycle();
      if (o_req && o_gnt) grants++;
    end
    n_cmp++;
    if (grants != 4 || o_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL stall: got grants %0d req %b valid %b pc %h want 4 0 1 %h",
               grants, o_req, o_valid, o_pc, RESET_PC);
    end
    ready_pct = 100;
    seen = 1'b0; first_pc = 32'hFFFF_FFFF;
    repeat (8) begin
      cycle();
      if (o_xfer && !seen) begin seen = 1'b1; first_pc = o_pc; end
    end
    n_cmp++;
    if (first_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", first_pc, RESET_PC);
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] first_pc;
    bit seen;
    int stale;
    knobs(100, 100, 4, 4);
    do_reset();
    repeat (3) cycle();
    redir_now = 1'b1; redir_pc_now = 32'h0000_0100;
    cycle();
    redir_now = 1'b0;
    seen = 1'b0; stale = 0; first_pc = 32'hFFFF_FFFF;
    repeat (16) begin
      cycle();
      if (o_xfer) begin
        if (!seen) begin seen = 1'b1; first_pc = o_pc; end
        if (o_pc < 32'h100) stale++;
      end
    end
    n_cmp++;
    if (first_pc !== 32'h100 || stale != 0) begin
      n_fail++;
      $display("FAIL redirect_inflight: got first %h stale %0d want 100 0", first_pc, stale);
    end
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] first_pc;
    bit seen;
    knobs(100, 100, 2, 2);
    do_reset();
    repeat (8) cycle();
    redir_now = 1'b1; redir_pc_now = 32'h0000_0200;
    cycle();
    redir_now = 1'b0;
    n_cmp++;
    if (o_rv !== 1'b1 || o_xfer !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_no_xfer: got rvalid %b xfer %b want 1 0", o_rv, o_xfer);
    end
    cycle();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect_issue: got req %b addr %h want 1 200", o_req, o_addr);
    end
    seen = 1'b0; first_pc = 32'hFFFF_FFFF;
    repeat (10) begin
      cycle();
      if (o_xfer && !seen) begin seen = 1'b1; first_pc = o_pc; end
    end
    n_cmp++;
    if (first_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect_first_pc: got %h want 200", first_pc);
    end
  endtask

  task automatic test_gnt_low();
    logic [31:0] a0;
    knobs(100, 100, 1, 1);
    do_reset();
    repeat (5) cycle();
    gnt_pct = 0;
    cycle();
    a0 = o_addr;
    repeat (4) begin
      cycle();
      n_cmp++;
      if (o_req !== 1'b1 || o_addr !== a0) begin
        n_fail++;
        $display("FAIL addr_hold: got req %b addr %h want 1 %h", o_req, o_addr, a0);
      end
    end
    gnt_pct = 100;
    repeat (6) cycle();
  endtask

  task automatic test_unaligned();
    knobs(100, 100, 1, 2);
    repeat (4) cycle();
    redir_now = 1'b1; redir_pc_now = 32'h0000_1003;
    cycle();
    redir_now = 1'b0;
    cycle();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL unaligned: got req %b addr %h want 1 1000", o_req, o_addr);
    end
    repeat (8) cycle();
  endtask

  task automatic test_midreset();
    knobs(100, 100, 2, 2);
    repeat (8) cycle();
    rst_now = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (o_req !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got req %b valid %b want 0 0", o_req, o_valid);
    end
    rst_now = 1'b0;
    cycle();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL midreset_restart: got req %b addr %h want 1 %h", o_req, o_addr, RESET_PC);
    end
    repeat (8) cycle();
  endtask

  task automatic test_random();
    knobs(60, 70, 1, 4);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gnt_pct   = 30 + int'($urandom_range(70));
      ready_pct = 20 + int'($urandom_range(80));
      redir_now = $urandom_range(99) < 3;
      redir_pc_now = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      rst_now   = $urandom_range(999) < 3;
      cycle();
    end
    knobs(100, 100, 1, 1);
  endtask

  initial begin
    reset_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b0;
    prev_rst = 1'b0; redir_pc_now = 32'h0; exp_pc = RESET_PC;
    knobs(100, 100, 1, 1);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_gnt_low();
    test_unaligned();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
